div_unit: RTL

- Iterative RV32M divider.
- Acts as the responder to the execute stage, which issues DIV/DIVU/REM/REMU operands and consumes div2mem_divvalid / div2mem_wr_wdata when forming ex2mem_wr_wdata.
- Radix-2 restoring algorithm, one quotient bit per cycle.
- Divide-by-zero and signed overflow complete early.

---
 rtl/div_unit.sv | 129 ++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Divide-by-zero and signed overflow finish in one cycle; all other operations take 32 iterations.
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex2div_start,
    input  logic [1:0]      ex2div_op,
    input  logic [XLEN-1:0] ex2div_oprand1,
    input  logic [XLEN-1:0] ex2div_oprand2,
    input  logic            ex2div_flush,
    output logic            div2ex_busy,
    output logic            div2mem_divvalid,
    output logic [XLEN-1:0] div2mem_wr_wdata
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic            negq_q, negq_d;
    logic            negr_q, negr_d;
    logic            rem_sel_q, rem_sel_d;
    logic [XLEN-1:0] wdata_q, wdata_d;

    logic            is_signed;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN:0]   shifted, diff;
    logic            ge;
    logic [XLEN-1:0] rem_step, quo_step;

    // Operand magnitudes; 0x80000000 negates to itself, which is the correct unsigned magnitude 2^31.
    assign is_signed = ~ex2div_op[0];
    assign a_mag = (is_signed & ex2div_oprand1[XLEN-1]) ? -ex2div_oprand1 : ex2div_oprand1;
    assign b_mag = (is_signed & ex2div_oprand2[XLEN-1]) ? -ex2div_oprand2 : ex2div_oprand2;

    // One restoring step on the 33-bit partial remainder so divisors >= 2^31 cannot overflow.
    assign shifted  = {rem_q, quo_q[XLEN-1]};
    assign ge       = (shifted >= {1'b0, dvs_q});
    assign diff     = shifted - {1'b0, dvs_q};
    assign rem_step = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    assign quo_step = {quo_q[XLEN-2:0], ge};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        negq_d    = negq_q;
        negr_d    = negr_q;
        rem_sel_d = rem_sel_q;
        wdata_d   = wdata_q;
        case (state_q)
            IDLE: begin
                if (ex2div_start && !ex2div_flush) begin
                    dvs_d     = b_mag;
                    rem_d     = '0;
                    quo_d     = a_mag;
                    negq_d    = is_signed & (ex2div_oprand1[XLEN-1] ^ ex2div_oprand2[XLEN-1]);
                    negr_d    = is_signed & ex2div_oprand1[XLEN-1];
                    rem_sel_d = ex2div_op[1];
                    cnt_d     = '0;
                    if (ex2div_oprand2 == '0) begin
                        wdata_d = ex2div_op[1] ? ex2div_oprand1 : '1;
                        state_d = DONE;
                    end else if (is_signed && ex2div_oprand1 == MIN_NEG && ex2div_oprand2 == '1) begin
                        wdata_d = ex2div_op[1] ? '0 : MIN_NEG;
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (ex2div_flush) begin
                    state_d = IDLE;
                end else begin
                    rem_d = rem_step;
                    quo_d = quo_step;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        wdata_d = rem_sel_q ? (negr_q ? -rem_step : rem_step)
                                            : (negq_q ? -quo_step : quo_step);
                        state_d = DONE;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            negq_q    <= 1'b0;
            negr_q    <= 1'b0;
            rem_sel_q <= 1'b0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            negq_q    <= negq_d;
            negr_q    <= negr_d;
            rem_sel_q <= rem_sel_d;
            wdata_q   <= wdata_d;
        end
    end

    // A flush landing on the DONE cycle kills the result pulse.
    assign div2ex_busy      = (state_q != IDLE);
    assign div2mem_divvalid = (state_q == DONE) && !ex2div_flush;
    assign div2mem_wr_wdata = wdata_q;

endmodule
